// File: rtl/dll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dll_ctrl_pkg
// Description : Shared types for the FMDLL lock controller: FSM states,
//               tracking step direction and the lock-sample classifier.
// Revision    : 1.0
// ============================================================================
package dll_ctrl_pkg;

  localparam int CODE_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAR_WAIT   = 3'd1,
    ST_SAR_DECIDE = 3'd2,
    ST_TRACK_WAIT = 3'd3,
    ST_TRACK_STEP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  // A sample counts towards lock when it holds, or when it turns around
  // against an earlier real move. A clipped step never counts as settled.
  function automatic logic is_nonmono(input dir_t dir, input dir_t prev,
                                      input logic clipped);
    return !clipped &&
           ((dir == DIR_NONE) || ((prev != DIR_NONE) && (dir != prev)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dll_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : dll_settle_timer
// Description : Settle-delay counter shared by the SAR and tracking wait
//               states. Held at zero by load_i; while en_i is high it counts
//               up and flags done_o on the SETTLE_CYC-th waiting cycle.
// Revision    : 1.0
// ============================================================================
module dll_settle_timer #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk_ext,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] c_last = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Count waiting cycles; park at the terminal value until reloaded.
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != c_last)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = en_i && (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/dll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dll_lock_ctrl
// Description : FMDLL delay-line controller. Successive-approximation search
//               of the DCDL code from phase-detector flags, followed by
//               bang-bang tracking with lock / loss-of-lock detection.
//               Optional macro DLL_LOCK_CTRL_OVR_EN adds ovr_en / ovr_code
//               for a direct code override that parks the FSM in IDLE.
// Revision    : 1.0
// ============================================================================
module dll_lock_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pd_lead,
  input  logic              pd_lag,
`ifdef DLL_LOCK_CTRL_OVR_EN
  input  logic              ovr_en,
  input  logic [CODE_W-1:0] ovr_code,
`endif
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              locked,
  output logic              lost_lock,
  output logic              sat
);

  localparam int IDXW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int LCW  = $clog2(LOCK_CNT + 1);
  localparam int UCW  = $clog2(UNLOCK_CNT + 1);

  localparam logic [CODE_W-1:0] c_code_max = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] c_code_msb = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [IDXW-1:0]   c_idx_top  = IDXW'(CODE_W - 1);
  localparam logic [LCW-1:0]    c_lock_tgt = LCW'(LOCK_CNT);
  localparam logic [UCW-1:0]    c_unl_tgt  = UCW'(UNLOCK_CNT);

  state_t            state_q;
  logic [CODE_W-1:0] code_q;
  logic [IDXW-1:0]   idx_q;
  logic [LCW-1:0]    lock_cnt_q;
  logic [UCW-1:0]    unlock_cnt_q;
  dir_t              prev_dir_q;
  logic              busy_q;
  logic              locked_q;
  logic              lost_lock_q;
  logic              sat_q;

  logic              in_wait;
  logic              settle_done;

  logic [CODE_W-1:0] sar_code_d;
  logic [CODE_W-1:0] step_code_d;
  dir_t              dir_d;
  logic              clip_d;
  logic              nonmono_d;
  logic [LCW-1:0]    lock_inc_d;
  logic [UCW-1:0]    unlock_inc_d;

  assign in_wait = (state_q == ST_SAR_WAIT) || (state_q == ST_TRACK_WAIT);

  dll_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk_ext (clk_ext),
    .rst     (rst),
    .load_i  (!in_wait),
    .en_i    (in_wait),
    .done_o  (settle_done)
  );

  // Next SAR code: resolve the current bit from pd_lag, trial-set the next.
  always_comb begin
    sar_code_d = code_q;
    if (pd_lag) begin
      sar_code_d[idx_q] = 1'b0;
    end
    if (idx_q != '0) begin
      sar_code_d[idx_q - 1'b1] = 1'b1;
    end
  end

  // Tracking step: direction from the flags, clipping, lock-sample class.
  always_comb begin
    dir_d = DIR_NONE;
    if (pd_lead && !pd_lag) begin
      dir_d = DIR_UP;
    end else if (pd_lag && !pd_lead) begin
      dir_d = DIR_DN;
    end
    clip_d = ((dir_d == DIR_UP) && (code_q == c_code_max)) ||
             ((dir_d == DIR_DN) && (code_q == '0));
    step_code_d = code_q;
    if (!clip_d) begin
      if (dir_d == DIR_UP) begin
        step_code_d = code_q + 1'b1;
      end else if (dir_d == DIR_DN) begin
        step_code_d = code_q - 1'b1;
      end
    end
    nonmono_d    = is_nonmono(dir_d, prev_dir_q, clip_d);
    lock_inc_d   = lock_cnt_q + 1'b1;
    unlock_inc_d = unlock_cnt_q + 1'b1;
  end

  // Main controller FSM with all outputs registered.
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      code_q       <= '0;
      idx_q        <= c_idx_top;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
      prev_dir_q   <= DIR_NONE;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      lost_lock_q  <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      lost_lock_q <= 1'b0;
`ifdef DLL_LOCK_CTRL_OVR_EN
      if (ovr_en) begin
        // Override owns the code and keeps the loop parked.
        state_q  <= ST_IDLE;
        code_q   <= ovr_code;
        busy_q   <= 1'b0;
        locked_q <= 1'b0;
      end else
`endif
      if (stop) begin
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_SAR_WAIT;
              code_q  <= c_code_msb;
              idx_q   <= c_idx_top;
              busy_q  <= 1'b1;
            end
          end

          ST_SAR_WAIT: begin
            if (settle_done) begin
              state_q <= ST_SAR_DECIDE;
            end
          end

          ST_SAR_DECIDE: begin
            code_q <= sar_code_d;
            if (idx_q != '0) begin
              idx_q   <= idx_q - 1'b1;
              state_q <= ST_SAR_WAIT;
            end else begin
              state_q      <= ST_TRACK_WAIT;
              lock_cnt_q   <= '0;
              unlock_cnt_q <= '0;
              prev_dir_q   <= DIR_NONE;
            end
          end

          ST_TRACK_WAIT: begin
            if (settle_done) begin
              state_q <= ST_TRACK_STEP;
            end
          end

          ST_TRACK_STEP: begin
            state_q    <= ST_TRACK_WAIT;
            code_q     <= step_code_d;
            prev_dir_q <= dir_d;
            if (dir_d != DIR_NONE) begin
              sat_q <= clip_d;
            end
            if (!locked_q) begin
              if (nonmono_d) begin
                lock_cnt_q <= lock_inc_d;
                if (lock_inc_d == c_lock_tgt) begin
                  locked_q     <= 1'b1;
                  unlock_cnt_q <= '0;
                end
              end else begin
                lock_cnt_q <= '0;
              end
            end else begin
              if (!nonmono_d) begin
                if (unlock_inc_d == c_unl_tgt) begin
                  locked_q     <= 1'b0;
                  lost_lock_q  <= 1'b1;
                  lock_cnt_q   <= '0;
                  unlock_cnt_q <= '0;
                end else begin
                  unlock_cnt_q <= unlock_inc_d;
                end
              end else begin
                unlock_cnt_q <= '0;
              end
            end
          end

          default: begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign code      = code_q;
  assign busy      = busy_q;
  assign locked    = locked_q;
  assign lost_lock = lost_lock_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dll_lock_ctrl
// Description : Self-checking bench for dll_lock_ctrl: vector table, directed
//               acquisition/tracking sequences and randomized stimulus
//               against a behavioural reference model.
// Revision    : 1.0
// ============================================================================
module tb_dll_lock_ctrl;

  localparam int CODE_W = 10;
  localparam int SETTLE = 4;
  localparam int LOCKN  = 8;
  localparam int UNLOCKN = 4;
  localparam int MAXC   = (1 << CODE_W) - 1;

  logic              clk_ext;
  logic              rst, start, stop, pd_lead, pd_lag;
  logic [CODE_W-1:0] code;
  logic              busy, locked, lost_lock, sat;
`ifdef DLL_LOCK_CTRL_OVR_EN
  logic              ovr_en;
  logic [CODE_W-1:0] ovr_code;
`endif

  dll_lock_ctrl #(
    .CODE_W     (CODE_W),
    .SETTLE_CYC (SETTLE),
    .LOCK_CNT   (LOCKN),
    .UNLOCK_CNT (UNLOCKN)
  ) dut (
    .clk_ext   (clk_ext),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pd_lead   (pd_lead),
    .pd_lag    (pd_lag),
`ifdef DLL_LOCK_CTRL_OVR_EN
    .ovr_en    (ovr_en),
    .ovr_code  (ovr_code),
`endif
    .code      (code),
    .busy      (busy),
    .locked    (locked),
    .lost_lock (lost_lock),
    .sat       (sat)
  );

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // m_mode: 0 idle, 1 searching, 2 tracking. m_wait = edges left before the
  // next decision/step edge. m_run counts towards lock or unlock.
  int m_mode = 0, m_wait = 0, m_bit = CODE_W - 1, m_code = 0;
  int m_busy = 0, m_locked = 0, m_lost = 0, m_sat = 0, m_run = 0, m_prev = 0;

  task automatic model_edge();
    int dir;
    bit clipped, nonmono;
    m_lost = 0;
    if (rst) begin
      m_mode = 0; m_code = 0; m_busy = 0; m_locked = 0; m_sat = 0;
      m_run = 0; m_prev = 0; m_bit = CODE_W - 1; m_wait = 0;
      return;
    end
`ifdef DLL_LOCK_CTRL_OVR_EN
    if (ovr_en) begin
      m_mode = 0; m_code = int'(ovr_code); m_busy = 0; m_locked = 0;
      return;
    end
`endif
    if (stop) begin
      m_mode = 0; m_busy = 0; m_locked = 0;
      return;
    end
    case (m_mode)
      0: if (start) begin
           m_mode = 1; m_code = 1 << (CODE_W - 1); m_bit = CODE_W - 1;
           m_wait = SETTLE; m_busy = 1;
         end
      1: if (m_wait > 0) m_wait--;
         else begin
           if (pd_lag) m_code -= (1 << m_bit);
           if (m_bit > 0) begin
             m_bit--; m_code += (1 << m_bit); m_wait = SETTLE;
           end else begin
             m_mode = 2; m_wait = SETTLE; m_run = 0; m_prev = 0;
           end
         end
      2: if (m_wait > 0) m_wait--;
         else begin
           dir = (pd_lead && !pd_lag) ? 1 : ((pd_lag && !pd_lead) ? -1 : 0);
           clipped = (m_code + dir > MAXC) || (m_code + dir < 0);
           if (!clipped) m_code += dir;
           if (dir != 0) m_sat = clipped;
           nonmono = !clipped && (dir == 0 || (m_prev != 0 && dir != m_prev));
           m_prev = dir;
           if (!m_locked) begin
             if (nonmono) begin
               m_run++;
               if (m_run == LOCKN) begin m_locked = 1; m_run = 0; end
             end else m_run = 0;
           end else begin
             if (!nonmono) begin
               m_run++;
               if (m_run == UNLOCKN) begin m_locked = 0; m_lost = 1; m_run = 0; end
             end else m_run = 0;
           end
           m_wait = SETTLE;
         end
      default: ;
    endcase
  endtask

  always @(posedge clk_ext) model_edge();

  // Every cycle: DUT outputs versus the model, plus a lost_lock tally.
  int lost_seen = 0;
  always @(negedge clk_ext) begin
    if (lost_lock) lost_seen++;
    check("cycle.code", int'(code), m_code);
    check("cycle.flags", int'({busy, locked, lost_lock, sat}),
          (m_busy << 3) | (m_locked << 2) | (m_lost << 1) | m_sat);
  end

  // ---------------- stimulus helpers ----------------
  bit auto_pd = 0;
  int target  = 0;

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk_ext);
      if (auto_pd) begin
        pd_lead = (m_code < target);
        pd_lag  = (m_code > target);
      end
    end
  endtask

  typedef struct {
    bit rst, start, stop, lead;
    int exp_code;
    bit exp_busy, exp_locked;
  } vec_t;

  vec_t vecs[9];
  bit   ever_locked;
  int   guard;

  initial begin
    rst = 1; start = 0; stop = 0; pd_lead = 0; pd_lag = 0;
`ifdef DLL_LOCK_CTRL_OVR_EN
    ovr_en = 0; ovr_code = '0;
`endif
    vecs[0] = '{1, 0, 0, 0,   0, 0, 0};  // reset
    vecs[1] = '{0, 0, 0, 0,   0, 0, 0};  // idle holds
    vecs[2] = '{0, 1, 1, 0,   0, 0, 0};  // start+stop: stop wins
    vecs[3] = '{0, 1, 0, 0, 512, 1, 0};  // start loads MSB
    vecs[4] = '{0, 0, 0, 1, 512, 1, 0};  // settling, code steady
    vecs[5] = '{0, 0, 1, 0, 512, 0, 0};  // stop: code held
    vecs[6] = '{0, 1, 0, 0, 512, 1, 0};  // restart
    vecs[7] = '{0, 0, 0, 0, 512, 1, 0};
    vecs[8] = '{1, 0, 0, 0,   0, 0, 0};  // reset mid-search
    @(negedge clk_ext);
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      pd_lead = vecs[i].lead; pd_lag = 0;
      @(negedge clk_ext);
      check($sformatf("vec%0d.code", i), int'(code), vecs[i].exp_code);
      check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].exp_busy));
      check($sformatf("vec%0d.locked", i), int'(locked), int'(vecs[i].exp_locked));
    end
    rst = 0; start = 0; stop = 0; pd_lead = 0;

    // Acquire target 300: SAR trajectory, then lock on holds.
    target = 300; auto_pd = 1;
    start = 1; cycles(1); start = 0;
    check("sar.c0", int'(code), 512);
    cycles(5); check("sar.c1", int'(code), 256);
    cycles(5); check("sar.c2", int'(code), 384);
    cycles(5); check("sar.c3", int'(code), 320);
    cycles(5); check("sar.c4", int'(code), 288);
    cycles(30); check("sar.final", int'(code), 300);
    check("sar.unlocked", int'(locked), 0);
    cycles(45);
    check("lock300.locked", int'(locked), 1);

    // Move target: loss of lock, re-track, relock.
    lost_seen = 0; target = 310;
    cycles(150);
    check("move.code", int'(code), 310);
    check("move.relocked", int'(locked), 1);
    check("move.lost_pulses", lost_seen, 1);

    // Stop while in a tracking wait.
    guard = 0;
    while (!(m_mode == 2 && m_wait > 0) && guard < 20) begin cycles(1); guard++; end
    check("stop.reach_wait", int'(guard < 20), 1);
    lost_seen = 0;
    stop = 1; cycles(1); stop = 0;
    check("stop.code", int'(code), 310);
    check("stop.busy", int'(busy), 0);
    check("stop.locked", int'(locked), 0);
    cycles(3);
    check("stop.no_lost", lost_seen, 0);

    // Reset during search at bit 5, then restart.
    target = 300;
    start = 1; cycles(1); start = 0;
    cycles(22);
    rst = 1; cycles(1); rst = 0;
    check("rst.code", int'(code), 0);
    check("rst.busy", int'(busy), 0);
    start = 1; cycles(1); start = 0;
    check("restart.code", int'(code), 512);
    stop = 1; cycles(1); stop = 0;

    // Lead stuck high: search to max, tracking clips, never locks.
    auto_pd = 0; pd_lead = 1; pd_lag = 0;
    start = 1; cycles(1); start = 0;
    cycles(50);
    check("sat.code", int'(code), MAXC);
    ever_locked = 0;
    for (int i = 0; i < 80; i++) begin cycles(1); if (locked) ever_locked = 1; end
    check("sat.flag", int'(sat), 1);
    check("sat.never_locked", int'(ever_locked), 0);
    stop = 1; cycles(1); stop = 0;

`ifdef DLL_LOCK_CTRL_OVR_EN
    target = 300; auto_pd = 1;
    start = 1; cycles(1); start = 0;
    cycles(12);
    ovr_en = 1; ovr_code = 10'd77; cycles(1);
    check("ovr.code", int'(code), 77);
    check("ovr.busy", int'(busy), 0);
    start = 1; cycles(2);
    check("ovr.start_ignored", int'(busy), 0);
    ovr_en = 0; start = 0; cycles(2);
    check("ovr.retained", int'(code), 77);
    start = 1; cycles(1); start = 0;
    check("ovr.resume", int'(code), 512);
    auto_pd = 0;
`endif

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ((i % 400) == 0) begin
        auto_pd = ($urandom_range(0, 1) == 1);
        target  = $urandom_range(0, MAXC);
      end
      rst   = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 9) == 0);
`ifdef DLL_LOCK_CTRL_OVR_EN
      ovr_en   = ($urandom_range(0, 199) == 0);
      ovr_code = CODE_W'($urandom_range(0, MAXC));
`endif
      if (!auto_pd) begin
        pd_lead = ($urandom_range(0, 2) == 0);
        pd_lag  = ($urandom_range(0, 2) == 0);
      end
      cycles(1);
    end
    rst = 0; stop = 0; start = 0;
`ifdef DLL_LOCK_CTRL_OVR_EN
    ovr_en = 0;
`endif
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
